// File: rtl/matmul_sequencer.sv
// Load/unload sequencer for a 3x3 matrix-multiply datapath: streams W then X into the
// memory bank, runs three unload/MAC phases, drains, and pulses done. Option: SEQ_PERF_CNT_EN.
module matmul_sequencer #(
    parameter int DW    = 4,
    parameter int DRAIN = 2
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          start,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic [DW-1:0] mem_data,
    output logic          load_w,
    output logic          load_x,
    output logic          unload1,
    output logic          unload2,
    output logic          unload3,
    output logic          mac_clr,
    output logic          mac_en,
    output logic          busy,
    output logic          done
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [15:0]   cycle_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_W, S_LOAD_X, S_FLUSH, S_UNLOAD, S_DRAIN, S_DONE
    } state_t;

    localparam logic [3:0] LAST_ELEM  = 4'd8;
    localparam logic [3:0] LAST_PHASE = 4'd2;
    localparam logic [3:0] LAST_DRAIN = 4'(DRAIN - 1);

    state_t     r_state, w_next;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic       w_xfer;

    assign w_xfer = in_valid & in_ready;

    // r_cnt is shared: element index in the load states, phase index in UNLOAD,
    // idle-cycle index in DRAIN.
    always_comb begin
        w_next    = r_state;
        w_cnt_nxt = r_cnt;
        in_ready  = 1'b0;
        unload1   = 1'b0;
        unload2   = 1'b0;
        unload3   = 1'b0;
        mac_en    = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next    = S_LOAD_W;
                    w_cnt_nxt = 4'd0;
                end
            end
            S_LOAD_W: begin
                in_ready = 1'b1;
                if (w_xfer) begin
                    if (r_cnt == LAST_ELEM) begin
                        w_next    = S_LOAD_X;
                        w_cnt_nxt = 4'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
            end
            S_LOAD_X: begin
                in_ready = 1'b1;
                if (w_xfer) begin
                    if (r_cnt == LAST_ELEM) begin
                        w_next    = S_FLUSH;
                        w_cnt_nxt = 4'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
            end
            S_FLUSH: begin
                w_next    = S_UNLOAD;
                w_cnt_nxt = 4'd0;
            end
            S_UNLOAD: begin
                mac_en  = 1'b1;
                unload1 = (r_cnt == 4'd0);
                unload2 = (r_cnt == 4'd1);
                unload3 = (r_cnt == LAST_PHASE);
                if (r_cnt == LAST_PHASE) begin
                    w_next    = S_DRAIN;
                    w_cnt_nxt = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            S_DRAIN: begin
                if (r_cnt == LAST_DRAIN) begin
                    w_next    = S_DONE;
                    w_cnt_nxt = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next    = S_IDLE;
                w_cnt_nxt = 4'd0;
            end
        endcase
    end

    // Write strobes and data lag the accepted transfer by one cycle; a transfer
    // coinciding with clear is dropped because clear takes priority.
    always_ff @(posedge clk) begin
        if (clear) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            mem_data <= '0;
            load_w   <= 1'b0;
            load_x   <= 1'b0;
            mac_clr  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nxt;
            load_w  <= w_xfer && (r_state == S_LOAD_W);
            load_x  <= w_xfer && (r_state == S_LOAD_X);
            mac_clr <= (r_state == S_IDLE) && start;
            if (w_xfer)
                mem_data <= in_data;
        end
    end

`ifdef SEQ_PERF_CNT_EN
    logic [15:0] r_cyc;

    always_ff @(posedge clk) begin
        if (clear)
            r_cyc <= 16'd0;
        else if (r_state == S_IDLE && start)
            r_cyc <= 16'd0;
        else if (busy && r_cyc != 16'hFFFF)
            r_cyc <= r_cyc + 16'd1;
    end

    assign cycle_count = r_cyc;
`endif

endmodule

// File: tb/tb_matmul_sequencer.sv
// Scoreboard bench for matmul_sequencer: stimulus queues expected strobes/timing,
// a negedge monitor pops and compares.
module tb_matmul_sequencer;
    localparam int DW  = 8;
    localparam int DRN = 2;

    logic          clk = 1'b0;
    logic          clear = 1'b1, start = 1'b0, in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, load_w, load_x, unload1, unload2, unload3;
    logic          mac_clr, mac_en, busy, done;
    logic [DW-1:0] mem_data;

    matmul_sequencer #(.DW(DW), .DRAIN(DRN)) dut (
        .clk(clk), .clear(clear), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_data(mem_data), .load_w(load_w), .load_x(load_x),
        .unload1(unload1), .unload2(unload2), .unload3(unload3),
        .mac_clr(mac_clr), .mac_en(mac_en), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { bit is_x; logic [DW-1:0] d; } ld_t;
    ld_t ld_q[$];
    int  done_q[$];
    int  clr_q[$];
    int  errors = 0, checks = 0;
    int  u1 = -100, u2 = -100, u3 = -100, nw = 0, nx = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (load_w | load_x) begin
            chk("load_onehot", int'(load_w & load_x), 0);
            if (ld_q.size() == 0) chk("unexpected_load", 1, 0);
            else begin
                ld_t e;
                e = ld_q.pop_front();
                chk("load_kind_x", int'(load_x), int'(e.is_x));
                chk("mem_data", int'(mem_data), int'(e.d));
            end
            if (load_w) nw++;
            if (load_x) nx++;
        end
        if (mac_clr) begin
            nw = 0; nx = 0;
            if (clr_q.size() == 0) chk("unexpected_mac_clr", 1, 0);
            else chk("mac_clr_cycle", cyc, clr_q.pop_front());
        end
        if (mac_en | unload1 | unload2 | unload3) begin
            chk("unload_onehot", $countones({unload1, unload2, unload3}), 1);
            chk("mac_en", int'(mac_en), 1);
        end
        if (unload1) u1 = cyc;
        if (unload2) u2 = cyc;
        if (unload3) u3 = cyc;
        if (done) begin
            if (done_q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                chk("done_cycle", cyc, done_q.pop_front());
                chk("unload1_cycle", u1, cyc - 3 - DRN);
                chk("unload2_cycle", u2, cyc - 2 - DRN);
                chk("unload3_cycle", u3, cyc - 1 - DRN);
                chk("load_w_count", nw, 9);
                chk("load_x_count", nx, 9);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start a job and feed n_el elements base, base+1, ...; gaps toggles in_valid 1,0,1,0.
    task automatic run_job(input int base, input int n_el, input bit gaps);
        int s, idx, stalls, guard;
        bit tog;
        step();
        start = 1'b1;
        s = cyc;
        clr_q.push_back(s + 1);
        step();
        start = 1'b0;
        idx = 0; stalls = 0; guard = 0; tog = 1'b1;
        while (idx < n_el && guard < 200) begin
            in_valid = gaps ? tog : 1'b1;
            in_data  = DW'(base + idx);
            @(negedge clk);
            if (in_valid && in_ready) begin
                ld_q.push_back('{is_x: (idx >= 9), d: DW'(base + idx)});
                idx++;
            end else if (!in_valid) begin
                stalls++;
            end
            tog = ~tog;
            step();
            guard++;
        end
        in_valid = 1'b0;
        if (idx < n_el) chk("feed_timeout", idx, n_el);
        // Back-to-back job with DRAIN=2: done 25 cycles after the start cycle.
        if (n_el == 18) done_q.push_back(s + 25 + stalls);
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((done_q.size() != 0 || busy) && g < 100) begin
            step();
            g++;
        end
        chk("job_complete_in_time", int'(g < 100), 1);
    endtask

    initial begin
        repeat (3) step();
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_strobes", int'({load_w, load_x, unload1, unload2, unload3, mac_clr, mac_en, done}), 0);
        chk("rst_mem_data", int'(mem_data), 0);
        step();
        clear = 1'b0;

        // Full back-to-back job, elements 1..18
        run_job(1, 18, 1'b0);
        wait_idle();

        // Backpressure: in_valid 1,0,1,0...
        run_job(100, 18, 1'b1);
        wait_idle();

        // Clear mid-LOAD_X after 4 X elements, with a transfer offered in the clear cycle
        run_job(40, 13, 1'b0);
        clear = 1'b1; in_valid = 1'b1; in_data = 8'd99;
        step();
        clear = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("clr_busy", int'(busy), 0);
        chk("clr_in_ready", int'(in_ready), 0);
        chk("clr_strobes", int'({load_w, load_x, unload1, unload2, unload3, mac_clr, mac_en, done}), 0);
        chk("clr_mem_data", int'(mem_data), 0);
        chk("clr_pending_loads", ld_q.size(), 0);

        // New job reloads W from element 0
        run_job(60, 18, 1'b0);
        wait_idle();

        // start pulsed during UNLOAD is ignored
        run_job(200, 18, 1'b0);
        begin
            int g;
            g = 0;
            while (g < 40) begin
                @(negedge clk);
                if (unload1) break;
                g++;
            end
            chk("unload_seen", int'(g < 40), 1);
        end
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_idle();
        repeat (3) step();

        // in_valid in IDLE is ignored
        in_valid = 1'b1; in_data = 8'h55;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("idle_in_ready", int'(in_ready), 0);
            chk("idle_busy", int'(busy), 0);
            step();
        end
        in_valid = 1'b0;

        // clear and start together: clear wins, start not remembered
        clear = 1'b1; start = 1'b1;
        step();
        clear = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("clr_start_busy", int'(busy), 0);
        step();
        @(negedge clk);
        chk("clr_start_busy_later", int'(busy), 0);
        repeat (4) step();

        chk("ld_q_drained", ld_q.size(), 0);
        chk("done_q_drained", done_q.size(), 0);
        chk("clr_q_drained", clr_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/matmul_sequencer.md
MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 SHALL have parameter DW, default 4, width of one matrix element.
REQ-002 SHALL have parameter DRAIN, default 2, idle cycles after the last unload phase before done (legal 1..15).
REQ-003 SHALL have port clk  input  1  rising-edge clock; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clear  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  job request, sampled in IDLE only.
REQ-006 SHALL have port in_valid  input  1  source has an element on in_data.
REQ-007 SHALL have port in_data  input  DW  element; W row-major first, then X.
REQ-008 SHALL have port in_ready  output  1  sequencer accepts an element this cycle.
REQ-009 SHALL have port mem_data  output  DW  registered element to the memory bank data input.
REQ-010 SHALL have ports load_w, load_x  output  1 each  memory bank write strobes.
REQ-011 SHALL have ports unload1, unload2, unload3  output  1 each  one-hot bank read-phase selects.
REQ-012 SHALL have ports mac_clr, mac_en  output  1 each  MAC array accumulator clear and enable.
REQ-013 SHALL have ports busy, done  output  1 each  job in progress; one-cycle completion pulse.

Function
REQ-014 SHALL implement states IDLE, LOAD_W, LOAD_X, FLUSH, UNLOAD, DRAIN, DONE; matrix size fixed 3x3 (9 elements per matrix).
REQ-015 IDLE: start=1 -> LOAD_W next cycle, mac_clr=1 for exactly that one cycle, element counter 0.
REQ-016 in_ready SHALL be 1 only in LOAD_W and LOAD_X; transfer = in_valid & in_ready; in_valid outside these states ignored.
REQ-017 Each transfer SHALL produce, the following cycle, mem_data=captured in_data with exactly one of load_w (LOAD_W) or load_x (LOAD_X) high for one cycle; both never high together.
REQ-018 Element counter SHALL count transfers 0..8; 9th transfer in LOAD_W -> LOAD_X with counter 0; 9th in LOAD_X -> FLUSH.
REQ-019 in_valid=0 SHALL stall the counter indefinitely with no timeout.
REQ-020 FLUSH SHALL last one cycle (final load_x pulse completes), in_ready=0, then UNLOAD.
REQ-021 UNLOAD SHALL last 3 cycles asserting unload1, unload2, unload3 in order, one per cycle, with mac_en=1 in each.
REQ-022 DRAIN SHALL last DRAIN cycles with all strobes low, then DONE.
REQ-023 DONE SHALL assert done=1 for one cycle, then IDLE.
REQ-024 busy SHALL be 1 in every state except IDLE; start while busy ignored.
REQ-025 With continuous in_valid and DRAIN=2, done SHALL assert 25 cycles after the cycle start is sampled.
REQ-026 Unused outputs in each state SHALL be 0; mem_data holds its last value.

Reset
REQ-027 clear=1 at a rising edge SHALL force IDLE, counters 0, and all outputs 0 including mem_data, from any state.
REQ-028 clear and start in the same cycle SHALL resolve to clear; start is not remembered.
REQ-029 A transfer in the clear cycle SHALL be discarded; no load strobe follows it.

Configuration
REQ-030 With SEQ_PERF_CNT_EN defined, SHALL add output cycle_count (16 bits): zeroed when start is accepted, +1 every busy cycle, saturates at 16'hFFFF, holds after done, zeroed by clear.
REQ-031 Without SEQ_PERF_CNT_EN, cycle_count and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-032 Reset: clear=1 mid-LOAD_X (after 4 X elements) -> next cycle busy=0, in_ready=0, all strobes 0; new start reloads W from element 0.
REQ-033 Full job: start, 18 back-to-back elements 1..18 -> load_w writes 1..9, load_x writes 10..18, unload1/2/3 in 3 consecutive cycles, done 25 cycles after start.
REQ-034 Backpressure: in_valid toggled 1,0,1,0 -> exactly one load strobe per transfer, 9 load_w and 9 load_x pulses total, done delayed by the stall count.
REQ-035 Ignored inputs: start pulsed during UNLOAD and in_valid=1 in IDLE -> no state change, no load strobes, in_ready stays 0.
REQ-036 With SEQ_PERF_CNT_EN and DRAIN=2, full back-to-back job -> cycle_count=25 at done, unchanged 10 cycles later.
